// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: default width, PC step and
// the next-PC source encoding.
package pc_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned PC_INC        = 4;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_RET,
    SRC_EXC
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the oldest
// entry. A pop has priority over a push, and a pop on an empty stack sets a sticky underflow flag.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_underflow;
  logic [PW-1:0]    w_top_idx;

  // r_ptr is the next write slot. When the stack is full, that slot holds the oldest entry.
  assign w_top_idx   = r_ptr - PW'(1);
  assign o_top       = r_mem[w_top_idx];
  assign o_empty     = r_empty;
  assign o_full      = r_full;
  assign o_underflow = r_underflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_pop) begin
      if (!r_empty) begin
        r_ptr   <= r_ptr - PW'(1);
        r_count <= r_count - CW'(1);
        r_empty <= (r_count == CW'(1));
        r_full  <= 1'b0;
      end else begin
        r_underflow <= 1'b1;
      end
    end else if (i_push) begin
      r_ptr   <= r_ptr + PW'(1);
      r_empty <= 1'b0;
      if (!r_full) begin
        r_count <= r_count + CW'(1);
        r_full  <= (r_count == CW'(DEPTH - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_pop) begin
      r_mem[r_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with next-PC priority select and an optional return-address stack.
// The stack is included when the macro PC_UNIT_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exception,
  input  logic [WIDTH-1:0] exc_vector,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two, at least 2");
  end

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_ret_target;
  logic [WIDTH-1:0] w_next_raw;
  logic [WIDTH-1:0] w_next;
  logic             w_adv;
  pc_src_e          w_src;

  assign w_pc_plus4 = r_pc + WIDTH'(PC_INC);
  assign pc_plus4   = w_pc_plus4;
  assign pc_out     = r_pc;
  // An exception overrides a stall.
  assign w_adv      = !stall || exception;

`ifdef PC_UNIT_RAS_EN
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_push;
  logic             w_pop;

  // A ret takes priority over a call, so a call+ret cycle does not push.
  assign w_pop  = w_adv && !exception && ret;
  assign w_push = w_adv && !exception && call && !ret;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_pc_plus4),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (ras_full),
    .o_underflow (ras_underflow)
  );

  assign ras_empty    = w_ras_empty;
  assign w_ret_target = w_ras_empty ? jump_target : w_ras_top;
`else
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;
  assign w_ret_target  = jump_target;
`endif

  always_comb begin
    w_src = SRC_SEQ;
    if (exception)           w_src = SRC_EXC;
    else if (ret)            w_src = SRC_RET;
    else if (jump || call)   w_src = SRC_JMP;
    else if (branch_taken)   w_src = SRC_BR;
  end

  always_comb begin
    w_next_raw = w_pc_plus4;
    unique case (w_src)
      SRC_EXC: w_next_raw = exc_vector;
      SRC_RET: w_next_raw = w_ret_target;
      SRC_JMP: w_next_raw = jump_target;
      SRC_BR:  w_next_raw = branch_target;
      default: w_next_raw = w_pc_plus4;
    endcase
  end

  assign w_next = {w_next_raw[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_VECTOR;
    end else if (w_adv) begin
      r_pc <= w_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit. It covers the stack behaviour when PC_UNIT_RAS_EN is defined
// and the jump-only behaviour otherwise.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        call;
  logic        ret;
  logic        exception;
  logic [31:0] exc_vector;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_underflow;

  int n_cmp;
  int n_err;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0),
    .RAS_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .exception     (exception),
    .exc_vector    (exc_vector),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; exception = 0;
    branch_target = '0; jump_target = '0; exc_vector = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    #3;
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
    n_cmp++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", ras_full); end
    n_cmp++; if (ras_underflow !== 1'b0) begin n_err++; $display("FAIL reset_uflow: got %b want 0", ras_underflow); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_plus4: got %h want %h", pc_plus4, 32'h4); end
    tick();
    rst = 1;
    tick();
    n_cmp++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL seq_1: got %h want %h", pc_out, 32'h4); end
    tick();
    n_cmp++; if (pc_out !== 32'h8) begin n_err++; $display("FAIL seq_2: got %h want %h", pc_out, 32'h8); end
    #2 rst = 0;
    #1;
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL async_reset: got %h want %h", pc_out, 32'h0); end
    #1 rst = 1;
  endtask

  task automatic test_stall();
    tick();
    n_cmp++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL pre_stall: got %h want %h", pc_out, 32'h4); end
    stall = 1; branch_taken = 1; branch_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, pc_out, 32'h4); end
    end
    exception = 1; exc_vector = 32'h80;
    tick();
    n_cmp++; if (pc_out !== 32'h80) begin n_err++; $display("FAIL stall_exc: got %h want %h", pc_out, 32'h80); end
    clear_inputs();
  endtask

  task automatic test_priority();
`ifdef PC_UNIT_RAS_EN
    call = 1; jump_target = 32'h700;
    tick();
    n_cmp++; if (pc_out !== 32'h700) begin n_err++; $display("FAIL prio_call: got %h want %h", pc_out, 32'h700); end
    call = 0;
`endif
    exception = 1; exc_vector = 32'h300; ret = 1; jump = 1; jump_target = 32'h40;
    branch_taken = 1; branch_target = 32'h500;
    tick();
    n_cmp++; if (pc_out !== 32'h300) begin n_err++; $display("FAIL prio_exc: got %h want %h", pc_out, 32'h300); end
`ifdef PC_UNIT_RAS_EN
    n_cmp++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL prio_exc_nopop: got %b want 0", ras_empty); end
`endif
    exception = 0;
    tick();
`ifdef PC_UNIT_RAS_EN
    n_cmp++; if (pc_out !== 32'h84) begin n_err++; $display("FAIL prio_ret: got %h want %h", pc_out, 32'h84); end
`else
    n_cmp++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL prio_ret: got %h want %h", pc_out, 32'h40); end
`endif
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL prio_empty: got %b want 1", ras_empty); end
    clear_inputs();
    call = 1; exception = 1; exc_vector = 32'h88; jump_target = 32'h900;
    tick();
    n_cmp++; if (pc_out !== 32'h88) begin n_err++; $display("FAIL exc_call_pc: got %h want %h", pc_out, 32'h88); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL exc_call_nopush: got %b want 1", ras_empty); end
    clear_inputs();
  endtask

`ifdef PC_UNIT_RAS_EN
  task automatic test_ras();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h504; exp_ret[1] = 32'h404; exp_ret[2] = 32'h304; exp_ret[3] = 32'h204;
    jump = 1; jump_target = 32'h100;
    tick();
    jump = 0; call = 1;
    for (int i = 0; i < 5; i++) begin
      jump_target = 32'h200 + 32'(i) * 32'h100;
      tick();
      n_cmp++; if (pc_out !== jump_target) begin n_err++; $display("FAIL call%0d: got %h want %h", i, pc_out, jump_target); end
    end
    n_cmp++; if (ras_full !== 1'b1) begin n_err++; $display("FAIL ras_full: got %b want 1", ras_full); end
    call = 0; ret = 1; jump_target = 32'h900;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (pc_out !== exp_ret[i]) begin n_err++; $display("FAIL ret%0d: got %h want %h", i, pc_out, exp_ret[i]); end
    end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
    n_cmp++; if (ras_underflow !== 1'b0) begin n_err++; $display("FAIL pre_uflow: got %b want 0", ras_underflow); end
    tick();
    n_cmp++; if (pc_out !== 32'h900) begin n_err++; $display("FAIL uflow_pc: got %h want %h", pc_out, 32'h900); end
    n_cmp++; if (ras_underflow !== 1'b1) begin n_err++; $display("FAIL uflow_flag: got %b want 1", ras_underflow); end
    call = 1; jump_target = 32'hA00;
    tick();
    n_cmp++; if (pc_out !== 32'hA00) begin n_err++; $display("FAIL callret_pc: got %h want %h", pc_out, 32'hA00); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL callret_nopush: got %b want 1", ras_empty); end
    clear_inputs();
    tick();
    n_cmp++; if (ras_underflow !== 1'b1) begin n_err++; $display("FAIL uflow_sticky: got %b want 1", ras_underflow); end
    call = 1; jump_target = 32'hB00;
    tick();
    clear_inputs();
  endtask
`else
  task automatic test_no_ras();
    call = 1; jump_target = 32'h40;
    tick();
    n_cmp++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL noras_call: got %h want %h", pc_out, 32'h40); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL noras_empty1: got %b want 1", ras_empty); end
    call = 0; ret = 1;
    tick();
    n_cmp++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL noras_ret: got %h want %h", pc_out, 32'h40); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL noras_empty2: got %b want 1", ras_empty); end
    n_cmp++; if (ras_underflow !== 1'b0) begin n_err++; $display("FAIL noras_uflow: got %b want 0", ras_underflow); end
    n_cmp++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL noras_full: got %b want 0", ras_full); end
    clear_inputs();
  endtask
`endif

  task automatic test_wrap();
    jump = 1; jump_target = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL align_jump: got %h want %h", pc_out, 32'hFFFF_FFFC); end
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want %h", pc_plus4, 32'h0); end
    jump = 0;
    tick();
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want %h", pc_out, 32'h0); end
    branch_taken = 1; branch_target = 32'h123;
    tick();
    n_cmp++; if (pc_out !== 32'h120) begin n_err++; $display("FAIL align_branch: got %h want %h", pc_out, 32'h120); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
`ifdef PC_UNIT_RAS_EN
    n_cmp++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL mid_pre_empty: got %b want 0", ras_empty); end
`endif
    #2 rst = 0;
    #1;
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL mid_rst_pc: got %h want %h", pc_out, 32'h0); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty: got %b want 1", ras_empty); end
    n_cmp++; if (ras_underflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_uflow: got %b want 0", ras_underflow); end
    tick();
    rst = 1;
    tick();
    n_cmp++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL post_rst_pc: got %h want %h", pc_out, 32'h4); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stall();
    test_priority();
`ifdef PC_UNIT_RAS_EN
    test_ras();
`else
    test_no_ras();
`endif
    test_wrap();
`ifdef PC_UNIT_RAS_EN
    call = 1; jump_target = 32'hC00;
    tick();
    clear_inputs();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
